// File: rtl/music_event_recorder_pkg.sv
// Shared types and default widths for the note-stream recorder and the players
// that read back its {note_on, note, delay} messages.
package music_event_recorder_pkg;

    localparam int NOTE_BITS_DEF  = 6;
    localparam int DELAY_BITS_DEF = 8;
    localparam int ADDR_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } rec_state_t;

    // Message layout, delay in the low bits: {note_on, note, delay}.
    function automatic int msg_delay_lsb();
        return 0;
    endfunction

    function automatic int msg_note_lsb(input int delay_bits);
        return delay_bits;
    endfunction

    function automatic int msg_on_bit(input int note_bits, input int delay_bits);
        return note_bits + delay_bits;
    endfunction

endpackage

// File: rtl/music_event_recorder_note_segment_timer.sv
// Tempo-tick counter for the current note segment; pulses sat_pulse on the tick
// that completes a full-length (all ones) segment and restarts from zero.
module note_segment_timer #(
    parameter int DELAY_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_en,
    input  logic                  clear,
    output logic [DELAY_BITS-1:0] cnt,
    output logic                  sat_pulse
);

    localparam logic [DELAY_BITS-1:0] CNT_MAX = '1;
    localparam logic [DELAY_BITS-1:0] CNT_SAT = {{(DELAY_BITS-1){1'b1}}, 1'b0};

    logic [DELAY_BITS-1:0] cnt_q;
    logic [DELAY_BITS-1:0] cnt_d;

    assign sat_pulse = tick_en && (cnt_q == CNT_SAT);
    assign cnt       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || sat_pulse) begin
            cnt_d = '0;
        end else if (tick_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/music_event_recorder.sv
// Records a live gate/note stream as {note_on, note, delay} messages written
// sequentially to a RAM port; msg_count is the resulting playback length.
module music_event_recorder
    import music_event_recorder_pkg::*;
#(
    parameter int NOTE_BITS  = NOTE_BITS_DEF,
    parameter int DELAY_BITS = DELAY_BITS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                            clk10Mhz,
    input  logic                            reset,
    input  logic                            tick,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            in_note_on,
    input  logic [NOTE_BITS-1:0]            in_note,
    output logic                            wr_en,
    output logic [ADDR_BITS-1:0]            wr_addr,
    output logic [1+NOTE_BITS+DELAY_BITS-1:0] wr_data,
    output logic [ADDR_BITS:0]              msg_count,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output rec_state_t                      state_dbg
);

    localparam int KEY_BITS = 1 + NOTE_BITS;
    localparam int MSG_BITS = KEY_BITS + DELAY_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

    rec_state_t              state_q, state_d;
    logic                    on_q;
    logic [NOTE_BITS-1:0]    note_q;
    logic [KEY_BITS-1:0]     key_q, key_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]    wr_addr_q, wr_addr_d;
    logic [MSG_BITS-1:0]     wr_data_q, wr_data_d;
    logic [ADDR_BITS:0]      msg_count_q, msg_count_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;

    logic [NOTE_BITS-1:0]    cur_note;
    logic [KEY_BITS-1:0]     cur_key;
    logic                    seg_change;
    logic                    emit_req;
    logic [DELAY_BITS-1:0]   emit_delay;
    logic [DELAY_BITS-1:0]   cnt;
    logic                    sat_pulse;

    // Note index is meaningless with the gate low, so rests all share one key.
    assign cur_note = on_q ? note_q : '0;
    assign cur_key  = {on_q, cur_note};

    note_segment_timer #(
        .DELAY_BITS (DELAY_BITS)
    ) u_timer (
        .clk       (clk10Mhz),
        .rst       (reset),
        .tick_en   ((state_q == RECORD) && tick),
        .clear     ((state_q != RECORD) || seg_change),
        .cnt       (cnt),
        .sat_pulse (sat_pulse)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        msg_count_d = msg_count_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        seg_change  = 1'b0;
        emit_req    = 1'b0;
        emit_delay  = cnt;

        case (state_q)
            IDLE, DONE: begin
                if (start && !stop) begin
                    state_d     = RECORD;
                    key_d       = cur_key;
                    wr_addr_d   = '0;
                    msg_count_d = '0;
                    done_d      = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            RECORD: begin
                // A tick on the change cycle still belongs to the old segment.
                seg_change = (cur_key != key_q);
                emit_delay = cnt + {{(DELAY_BITS-1){1'b0}}, tick};
                emit_req   = sat_pulse || (seg_change && (emit_delay != '0));
                key_d      = cur_key;
                if (stop) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                emit_req = (cnt != '0);
                state_d  = DONE;
                done_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit_req) begin
            if (msg_count_q == FULL_COUNT) begin
                overflow_d = 1'b1;
                state_d    = DONE;
                done_d     = 1'b1;
            end else begin
                wr_en_d     = 1'b1;
                wr_addr_d   = msg_count_q[ADDR_BITS-1:0];
                wr_data_d   = {key_q, emit_delay};
                msg_count_d = msg_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk10Mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            on_q        <= 1'b0;
            note_q      <= '0;
            key_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            msg_count_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            on_q        <= in_note_on;
            note_q      <= in_note;
            key_q       <= key_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            msg_count_q <= msg_count_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign msg_count = msg_count_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == RECORD) || (state_q == FLUSH);
    assign state_dbg = state_q;

endmodule
